delay_sched: RTL and testbench
==============================

# delay_sched

Shared-timer scheduler that time-multiplexes one programmable delay counter among NREQ requesters. Each requester asks for a delay of its own length; the block grants the timer round-robin, counts the delay, and returns a one-cycle completion pulse to the owner. It sits between the requesting control FSMs and the delay counter datapath, replacing one fixed-N counter per requester.

## Interface
- NREQ, 4, number of requesters (2..8)
- CBITS, 15, counter and delay-length width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  level request per requester; held until done or deliberately dropped
- len  in  NREQ*CBITS  requested delay per requester, slice i = len[i*CBITS +: CBITS]
- gnt  out  NREQ  one-hot owner of the timer, all-zero when idle
- done  out  NREQ  one-hot, one-cycle completion pulse to owner
- abort  out  1  one-cycle pulse when owner drops req mid-count
- busy  out  1  high in any state other than IDLE
- cnt  out  CBITS  current counter value

## Operation
- States: IDLE, COUNT, DONE.
- IDLE: if any req, pick winner via round-robin starting at ptr; latch len_q = len[winner], gnt <= onehot(winner), cnt <= 0, ptr <= winner+1 mod NREQ, go COUNT. No req: stay, outputs idle.
- COUNT: if req[owner] == 0: abort pulse, gnt <= 0, go IDLE (no done). Else if cnt == len_q: go DONE. Else cnt <= cnt + 1.
- DONE: done[owner] = 1 for this cycle only, gnt held this cycle; next edge gnt <= 0, cnt <= 0, go IDLE.
- len sampled only on grant; changes to len during COUNT are ignored.
- len = 0: COUNT lasts one cycle, then DONE.
- cnt never exceeds len_q; no wrap. len_q = 2^CBITS-1 is legal and counts fully.
- Owner keeping req high after done re-enters arbitration; other requesters win first if pending (ptr advanced).
- Simultaneous abort-drop and cnt == len_q in same COUNT cycle: abort wins, no done.
- Reset (asynchronous, any state): state=IDLE, gnt=0, done=0, abort=0, busy=0, cnt=0, ptr=0, len_q=0.

## Timing
- All outputs registered except done and abort, which decode state/owner combinationally from registered state (glitch-free one-hot).
- req sampled at edge k in IDLE -> gnt high from k (after edge), COUNT cycles hold cnt = 0..len_q, DONE cycle follows; done high in cycle k+len+2 after the sampling edge.
- Minimum one IDLE cycle between consecutive grants; back-to-back throughput = len+3 cycles per delay.
- abort asserted in the cycle after req falls is observed (COUNT samples req); gnt low the following cycle.
- busy = (state != IDLE), same cycle as gnt.

## Structure
- Package delay_sched_pkg: state enum (IDLE, COUNT, DONE), default NREQ and CBITS constants.
- Sub-module rr_arbiter: combinational round-robin pick from req vector and ptr, outputs one-hot winner and index; reused by other schedulers.
- Top holds FSM, len_q, cnt, ptr.

## Test plan
- Single requester: req[0]=1, len[0]=5 -> gnt=0001 next cycle, cnt 0..5, done[0] pulses 7 cycles after the sampling edge, gnt=0 after.
- All four request, len=2 each, held until done -> grants in order 0,1,2,3, each done 5 cycles apart (len+3), ptr wraps to 0.
- len=0 on req[2] -> one COUNT cycle, done[2] 2 cycles after sampling edge.
- Drop req[1] at cnt=3 of len=10 -> abort pulses once, no done[1], gnt=0, next pending requester granted after one IDLE cycle.
- Assert rst mid-COUNT (cnt=4) asynchronously -> all outputs 0 immediately, ptr=0; after release, req[3] and req[0] pending -> req[0] granted first.
- Change len[owner] from 8 to 2 during COUNT -> count still runs to 8.

Source files
------------

// File: rtl/delay_sched_pkg.sv
// Shared types and default sizing for the delay scheduler family.
package delay_sched_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NREQ_DEF  = 4;
    localparam int CBITS_DEF = 15;
endpackage

// File: rtl/delay_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NREQ. Returns one-hot winner, its index and a valid flag.
module rr_arbiter
    import delay_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         win_oh,
    output logic [$clog2(NREQ)-1:0] win_idx,
    output logic                    any
);
    localparam int IW = $clog2(NREQ);

    always_comb begin
        int c;
        c       = 0;
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            c = (int'(ptr) + i) % NREQ;
            if (!any && req[c]) begin
                any       = 1'b1;
                win_oh[c] = 1'b1;
                win_idx   = IW'(c);
            end
        end
    end
endmodule

// File: rtl/delay_sched.sv
// One programmable delay counter shared round-robin among NREQ requesters;
// the owner gets a one-cycle done pulse, or abort if it drops req mid-count.
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int CBITS = CBITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  abort,
    output logic                  busy,
    output logic [CBITS-1:0]      cnt
);
    localparam int IW = $clog2(NREQ);

    state_t          state, state_nx;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   next_ptr;
    logic [NREQ-1:0] win_oh;
    logic            win_any;
    logic [CBITS-1:0] len_q;
    logic            owner_req;
    logic            at_end;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (win_any)
    );

    // gnt is the registered one-hot owner, so masking req with it selects req[owner]
    assign owner_req = |(req & gnt);
    assign at_end    = (cnt == len_q);
    assign next_ptr  = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (win_any) state_nx = COUNT;
            COUNT: begin
                if (!owner_req)  state_nx = IDLE;
                else if (at_end) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        done  = '0;
        abort = 1'b0;
        busy  = (state != IDLE);
        case (state)
            COUNT:   abort = !owner_req;
            DONE:    done  = gnt;
            default: ;
        endcase
    end

    // Abort takes priority over reaching the end of the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        gnt   <= win_oh;
                        cnt   <= '0;
                        len_q <= len[int'(win_idx)*CBITS +: CBITS];
                        ptr   <= next_ptr;
                    end
                end
                COUNT: begin
                    if (!owner_req) begin
                        gnt <= '0;
                        cnt <= '0;
                    end else if (!at_end) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    gnt <= '0;
                    cnt <= '0;
                end
                default: begin
                    gnt <= '0;
                    cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_delay_sched.sv
// Directed bench for delay_sched with a transaction-level reference model.
module tb_delay_sched;
    localparam int N  = 4;
    localparam int CB = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*CB-1:0] len;
    logic [N-1:0]  gnt, done;
    logic          abort, busy;
    logic [CB-1:0] cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: owner (-1 = none), elapsed cycles since grant, latched length
    int m_own = -1;
    int m_t   = 0;
    int m_L   = 0;
    int m_ptr = 0;

    delay_sched #(.NREQ(N), .CBITS(CB)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .done  (done),
        .abort (abort),
        .busy  (busy),
        .cnt   (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_own = -1; m_t = 0; m_L = 0; m_ptr = 0;
        end else if (m_own < 0) begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (m_own < 0 && req[c]) begin
                    m_own = c;
                    m_L   = int'(len[c*CB +: CB]);
                    m_t   = 0;
                    m_ptr = (c + 1) % N;
                end
            end
        end else if (m_t <= m_L) begin
            if (!req[m_own]) m_own = -1;
            else             m_t++;
        end else begin
            m_own = -1;
        end
    endtask

    task automatic compare();
        logic [N-1:0] eg, ed;
        int ec;
        logic ea;
        eg = '0; ed = '0; ec = 0; ea = 1'b0;
        if (m_own >= 0) begin
            eg[m_own] = 1'b1;
            ec = (m_t < m_L) ? m_t : m_L;
            if (m_t == m_L + 1) ed[m_own] = 1'b1;
            ea = (m_t <= m_L) && !req[m_own];
        end
        chk("gnt",   32'(gnt),   32'(eg));
        chk("cnt",   32'(cnt),   32'(ec));
        chk("done",  32'(done),  32'(ed));
        chk("abort", 32'(abort), 32'(ea));
        chk("busy",  32'(busy),  32'(m_own >= 0));
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        compare();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int v);
        len[i*CB +: CB] = CB'(v);
    endtask

    task automatic wait_done(input int i, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done[i] && n < budget);
    endtask

    initial begin
        int n, cyc;
        int order[$];
        int dt[N];
        logic [N-1:0] prev_gnt;

        rst = 1'b1; req = '0; len = '0;
        repeat (2) tick();
        chk("rst gnt",  32'(gnt),  0);
        chk("rst cnt",  32'(cnt),  0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        @(posedge clk); #3 rst = 1'b0;
        tick();

        // single requester, len 5
        set_len(0, 5); req = 4'b0001;
        tick();
        chk("t1 gnt", 32'(gnt), 32'h1);
        chk("t1 cnt", 32'(cnt), 0);
        wait_done(0, 40, n);
        chk("t1 done latency", 32'(1 + n), 7);
        req = '0;
        tick();
        chk("t1 gnt after", 32'(gnt), 0);
        chk("t1 busy after", 32'(busy), 0);

        // all four, len 2 each, from a reset pointer
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < N; i++) begin set_len(i, 2); dt[i] = -1; end
        req = 4'b1111; prev_gnt = '0; cyc = 0;
        while (cyc < 60 && (req != 0 || gnt != 0)) begin
            tick(); cyc++;
            if (gnt != 0 && prev_gnt == 0)
                for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
            for (int i = 0; i < N; i++)
                if (done[i]) begin dt[i] = cyc; req[i] = 1'b0; end
            prev_gnt = gnt;
        end
        chk("t2 grant count", 32'(order.size()), 4);
        for (int k = 0; k < N; k++) begin
            chk("t2 grant order", (k < order.size()) ? 32'(order[k]) : 32'hffff, 32'(k));
            chk("t2 done time", 32'(dt[k]), 32'(4 + 5 * k));
        end
        req = 4'b0011; set_len(0, 2);
        tick();
        chk("t2 ptr wrap gnt", 32'(gnt), 32'h1);
        req[1] = 1'b0;
        wait_done(0, 20, n);
        chk("t2 wrap done", 32'(n), 3);
        req = '0; tick();

        // zero-length delay on requester 2
        set_len(2, 0); req = 4'b0100;
        wait_done(2, 10, n);
        chk("t3 len0 latency", 32'(n), 2);
        req = '0; tick();

        // abort of requester 1 at cnt 3, requester 3 pending
        set_len(1, 10); set_len(3, 1); req = 4'b0010;
        tick();
        chk("t4 gnt1", 32'(gnt), 32'h2);
        req[3] = 1'b1;
        for (int i = 0; i < 20 && cnt != 3; i++) tick();
        chk("t4 cnt at drop", 32'(cnt), 3);
        req[1] = 1'b0;
        #1;
        chk("t4 abort", 32'(abort), 1);
        chk("t4 no done", 32'(done), 0);
        tick();
        chk("t4 gnt idle", 32'(gnt), 0);
        chk("t4 abort once", 32'(abort), 0);
        tick();
        chk("t4 next gnt", 32'(gnt), 32'h8);
        wait_done(3, 10, n);
        chk("t4 req3 done", 32'(n), 2);
        req = '0; tick();

        // asynchronous reset mid-count
        set_len(2, 8); req = 4'b0100;
        for (int i = 0; i < 20 && !(gnt[2] && cnt == 4); i++) tick();
        chk("t5 cnt before rst", 32'(cnt), 4);
        #2 rst = 1'b1;
        #1;
        chk("t5 async gnt",  32'(gnt),   0);
        chk("t5 async cnt",  32'(cnt),   0);
        chk("t5 async busy", 32'(busy),  0);
        chk("t5 async abort", 32'(abort), 0);
        req = 4'b1001; set_len(0, 3); set_len(3, 3);
        @(posedge clk); #3 rst = 1'b0;
        tick();
        chk("t5 ptr reset gnt", 32'(gnt), 32'h1);
        wait_done(0, 20, n);
        chk("t5 done", 32'(n), 4);
        req = '0; tick();

        // len change during count is ignored
        set_len(0, 8); req = 4'b0001;
        tick();
        chk("t6 gnt", 32'(gnt), 32'h1);
        set_len(0, 2);
        wait_done(0, 30, n);
        chk("t6 latency", 32'(n), 9);
        req = '0; tick();

        // maximum length counts fully
        set_len(1, (1 << CB) - 1); req = 4'b0010;
        wait_done(1, 40000, n);
        chk("t7 max latency", 32'(n), 32'((1 << CB) + 1));
        chk("t7 max cnt", 32'(cnt), 32'((1 << CB) - 1));
        req = '0; tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
